axis_frame_crop: RTL and testbench

- Streaming region-of-interest cropper that sits directly upstream of the fsa block.
- Takes the full camera frame as an AXI4-Stream pixel stream and forwards only a configurable rectangular window.
- Regenerates tuser (start of frame) and tlast (end of line) for the cropped frame, so fsa sees a self-consistent frame of win_width x win_height pixels.
- Window configuration is latched per frame, so software can move the window without tearing.

---
 rtl/axis_frame_crop.sv | 179 +++++++++++++++++
 tb/tb_axis_frame_crop.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_crop.sv
// rtl/axis_frame_crop.sv - AXI-Stream region-of-interest cropper; define FRAME_CROP_STAT_EN for frame/drop statistics
module axis_frame_crop #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WW      = 12,
    parameter int C_IMG_HW      = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [C_IMG_WW-1:0]      win_left,
    input  logic [C_IMG_HW-1:0]      win_top,
    input  logic [C_IMG_WW-1:0]      win_width,
    input  logic [C_IMG_HW-1:0]      win_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     frm_done
`ifdef FRAME_CROP_STAT_EN
    ,
    output logic [31:0]              stat_frames,
    output logic [31:0]              stat_drops
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [C_IMG_WW-1:0] ONE_W  = {{(C_IMG_WW-1){1'b0}}, 1'b1};
    localparam logic [C_IMG_HW-1:0] ONE_H  = {{(C_IMG_HW-1){1'b0}}, 1'b1};
    localparam logic [C_IMG_WW:0]   ONE_WX = {{C_IMG_WW{1'b0}}, 1'b1};
    localparam logic [C_IMG_HW:0]   ONE_HX = {{C_IMG_HW{1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [C_IMG_WW-1:0] col;
    logic [C_IMG_HW-1:0] row;
    logic [C_IMG_WW-1:0] cfg_left;
    logic [C_IMG_WW-1:0] cfg_width;
    logic [C_IMG_HW-1:0] cfg_top;
    logic [C_IMG_HW-1:0] cfg_height;
    logic                out_frm_last;

    logic                accept;
    logic                sof;
    logic                active;
    logic                in_win;
    logic                col_end;
    logic                row_end;
    logic                load;
    logic [C_IMG_WW-1:0] eff_left;
    logic [C_IMG_WW-1:0] eff_width;
    logic [C_IMG_HW-1:0] eff_top;
    logic [C_IMG_HW-1:0] eff_height;
    logic [C_IMG_WW-1:0] pos_col;
    logic [C_IMG_HW-1:0] pos_row;
    logic [C_IMG_WW:0]   col_x;
    logic [C_IMG_WW:0]   left_x;
    logic [C_IMG_WW:0]   width_x;
    logic [C_IMG_HW:0]   row_x;
    logic [C_IMG_HW:0]   top_x;
    logic [C_IMG_HW:0]   height_x;

    // Ready only depends on the output register, never on the window test
    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign sof           = accept & s_axis_tuser;

    // A tuser beat is tested against the incoming window at position (0,0)
    assign eff_left   = s_axis_tuser ? win_left   : cfg_left;
    assign eff_width  = s_axis_tuser ? win_width  : cfg_width;
    assign eff_top    = s_axis_tuser ? win_top    : cfg_top;
    assign eff_height = s_axis_tuser ? win_height : cfg_height;
    assign pos_col    = s_axis_tuser ? '0 : col;
    assign pos_row    = s_axis_tuser ? '0 : row;

    // One extra bit keeps L+W and col-L free of wrap-around
    assign col_x    = {1'b0, pos_col};
    assign left_x   = {1'b0, eff_left};
    assign width_x  = {1'b0, eff_width};
    assign row_x    = {1'b0, pos_row};
    assign top_x    = {1'b0, eff_top};
    assign height_x = {1'b0, eff_height};

    assign active  = s_axis_tuser | (state == ST_RUN);
    assign in_win  = active & (col_x >= left_x) & ((col_x - left_x) < width_x)
                            & (row_x >= top_x)  & ((row_x - top_x)  < height_x);
    assign col_end = (col_x == (left_x + width_x - ONE_WX));
    assign row_end = (row_x == (top_x + height_x - ONE_HX));
    assign load    = accept & in_win;

    assign frm_done = m_axis_tvalid & m_axis_tready & out_frm_last;

    // Input position tracking; col saturates, row wraps
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                col <= '0;
                row <= pos_row + ONE_H;
            end else begin
                col <= (&pos_col) ? pos_col : pos_col + ONE_W;
                row <= pos_row;
            end
        end
    end

    // Window configuration is captured only on a frame start
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_left   <= '0;
            cfg_width  <= '0;
            cfg_top    <= '0;
            cfg_height <= '0;
        end else if (sof) begin
            cfg_left   <= win_left;
            cfg_width  <= win_width;
            cfg_top    <= win_top;
            cfg_height <= win_height;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state: tuser always (re)starts a frame; last window row's tlast ends it
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sof) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            ST_DONE: if (sof) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
        if (accept && active && s_axis_tlast && row_end) state_nxt = ST_DONE;
    end

    // Single output register stage; tlast is forced on a short window line
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            out_frm_last  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tuser  <= (pos_col == eff_left) & (pos_row == eff_top);
            m_axis_tlast  <= col_end | s_axis_tlast;
            out_frm_last  <= row_end & (col_end | s_axis_tlast);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef FRAME_CROP_STAT_EN
    // Saturating statistics: frames started and beats dropped
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_frames <= '0;
            stat_drops  <= '0;
        end else begin
            if (sof && !(&stat_frames))               stat_frames <= stat_frames + 32'd1;
            if (accept && !in_win && !(&stat_drops)) stat_drops  <= stat_drops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_crop.sv
// tb/tb_axis_frame_crop.sv - randomized self-checking bench for axis_frame_crop
module tb_axis_frame_crop;

    typedef struct {
        logic [7:0]  data;
        logic        user;
        logic        last;
        logic [11:0] l;
        logic [11:0] t;
        logic [11:0] w;
        logic [11:0] h;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       user;
        logic       last;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] win_left = '0;
    logic [11:0] win_top = '0;
    logic [11:0] win_width = '0;
    logic [11:0] win_height = '0;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        frm_done;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_out = 0;
    int         n_user = 0;
    int         n_done = 0;
    int         n_last = 0;
    bit         rnd = 1'b0;
    bit         hold_ready = 1'b0;
    logic [7:0] pix [20][40];
    beat_t      inq[$];
    exp_t       expq[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_user;
    logic       prev_last;

    axis_frame_crop #(.C_PIXEL_WIDTH(8), .C_IMG_WW(12), .C_IMG_HW(12)) dut (
        .clk(clk), .resetn(resetn),
        .win_left(win_left), .win_top(win_top), .win_width(win_width), .win_height(win_height),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .frm_done(frm_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is a raster of rows/cols; the expected output
    // follows directly from the window rectangle latched at the frame start.
    task automatic add_frame(input int fw, input int fh, input int l, input int t, input int w, input int h,
                             input int short_row, input int short_len, input int cut_row, input int cut_col,
                             input int chg_row, input bit sof, input logic [7:0] salt);
        beat_t b;
        exp_t  e;
        int    len;
        bit    keep;
        for (int r = 0; r < fh; r++) begin
            len = (r == short_row) ? short_len : fw;
            for (int c = 0; c < len; c++) begin
                if (r == cut_row && c == cut_col) return;
                b.data = pix[r][c] ^ salt;
                b.user = sof && r == 0 && c == 0;
                b.last = (c == len - 1);
                if (chg_row >= 0 && r >= chg_row) begin
                    b.l = 12'd0; b.t = 12'd0; b.w = 12'd40; b.h = 12'd20;
                end else begin
                    b.l = 12'(l); b.t = 12'(t); b.w = 12'(w); b.h = 12'(h);
                end
                inq.push_back(b);
                keep = sof && c >= l && c < l + w && r >= t && r < t + h;
                if (keep) begin
                    e.data = b.data;
                    e.user = (r == t && c == l);
                    e.last = (c == l + w - 1) || (c == len - 1);
                    e.done = e.last && (r == t + h - 1);
                    expq.push_back(e);
                end
            end
        end
    endtask

    task automatic send_beat(input beat_t b);
        bit acc;
        int n;
        while (rnd && $urandom_range(0, 1) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b.data;
        s_axis_tuser  = b.user;
        s_axis_tlast  = b.last;
        win_left      = b.l;
        win_top       = b.t;
        win_width     = b.w;
        win_height    = b.h;
        acc = 1'b0;
        n   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk); #1;
            n++;
            if (n > 2000) begin
                $display("FAIL accept_timeout got=0 exp=1");
                $fatal(1, "input never accepted");
            end
        end
    endtask

    task automatic run_stream();
        while (inq.size() != 0) send_beat(inq.pop_front());
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expq.size() != 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, expq.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        n_out = 0; n_user = 0; n_done = 0; n_last = 0;
    endtask

    // Downstream ready: always, random, or held low
    initial begin
        forever begin
            @(posedge clk); #1;
            m_axis_tready = hold_ready ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Output monitor: scoreboard compare, stall stability, stray frm_done
    always @(negedge clk) begin : mon
        exp_t e;
        if (resetn) begin
            if (prev_stall && m_axis_tvalid) begin
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_user", m_axis_tuser, prev_user);
                check("stall_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("out_data", m_axis_tdata, e.data);
                    check("out_user", m_axis_tuser, e.user);
                    check("out_last", m_axis_tlast, e.last);
                    check("out_done", frm_done, e.done);
                end
                n_out++;
                n_user += int'(m_axis_tuser);
                n_last += int'(m_axis_tlast);
                n_done += int'(frm_done);
            end else if (frm_done) begin
                check("done_no_hs", frm_done, 0);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_user  = m_axis_tuser;
            prev_last  = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        beat_t b;
        int fw, fh, l, t, w, h;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 40; c++)
                pix[r][c] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_done", frm_done, 0);
        resetn = 1'b1;
        #1;
        check("rst_tready", s_axis_tready, 1);

        // Basic crop, full throughput
        clr_stats(); rnd = 1'b0;
        add_frame(40, 20, 10, 5, 8, 4, -1, 0, -1, -1, -1, 1'b1, 8'h00);
        run_stream(); drain("t1_drain");
        check("t1_beats", n_out, 32);
        check("t1_tuser", n_user, 1);
        check("t1_tlast", n_last, 4);
        check("t1_done", n_done, 1);

        // Same frame with random valid/ready
        clr_stats(); rnd = 1'b1;
        add_frame(40, 20, 10, 5, 8, 4, -1, 0, -1, -1, -1, 1'b1, 8'h00);
        run_stream(); drain("t2_drain");
        check("t2_beats", n_out, 32);
        check("t2_done", n_done, 1);

        // Window moved mid-frame applies only to the next frame
        clr_stats();
        add_frame(40, 20, 10, 5, 8, 4, -1, 0, -1, -1, 2, 1'b1, 8'h11);
        add_frame(40, 20, 0, 0, 40, 20, -1, 0, -1, -1, -1, 1'b1, 8'h5a);
        run_stream(); drain("t3_drain");
        check("t3_beats", n_out, 832);
        check("t3_tlast", n_last, 24);
        check("t3_done", n_done, 2);

        // Restart by tuser in the middle of window row 6
        clr_stats();
        add_frame(40, 20, 10, 5, 8, 4, -1, 0, 6, 12, -1, 1'b1, 8'h33);
        add_frame(40, 20, 10, 5, 8, 4, -1, 0, -1, -1, -1, 1'b1, 8'h77);
        run_stream(); drain("t4_drain");
        check("t4_beats", n_out, 42);
        check("t4_tuser", n_user, 2);
        check("t4_done", n_done, 1);

        // Short input line 6 (14 pixels)
        clr_stats();
        add_frame(40, 20, 10, 5, 8, 4, 6, 14, -1, -1, -1, 1'b1, 8'h99);
        run_stream(); drain("t5_drain");
        check("t5_beats", n_out, 28);
        check("t5_tlast", n_last, 4);

        // Random frame geometry, windows possibly past the frame edges
        for (int k = 0; k < 4; k++) begin
            fw = $urandom_range(4, 40); fh = $urandom_range(2, 20);
            l = $urandom_range(0, fw);  t = $urandom_range(0, fh);
            w = $urandom_range(1, fw);  h = $urandom_range(1, fh);
            add_frame(fw, fh, l, t, w, h, $urandom_range(0, fh - 1), $urandom_range(1, fw),
                      -1, -1, -1, 1'b1, 8'($urandom));
        end
        run_stream(); drain("rnd_drain");

        // Reset while the output is stalled
        rnd = 1'b0; hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b.data = 8'ha5; b.user = 1'b1; b.last = 1'b0;
        b.l = 12'd0; b.t = 12'd0; b.w = 12'd8; b.h = 12'd4;
        send_beat(b);
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        check("t6_stall_valid", m_axis_tvalid, 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("t6_rst_valid", m_axis_tvalid, 0);
        hold_ready = 1'b0; rnd = 1'b1; clr_stats();
        add_frame(40, 20, 10, 5, 8, 4, -1, 0, -1, -1, -1, 1'b0, 8'h3c);
        add_frame(40, 20, 10, 5, 8, 4, -1, 0, -1, -1, -1, 1'b1, 8'hc3);
        run_stream(); drain("t6_drain");
        check("t6_beats", n_out, 32);
        check("t6_tuser", n_user, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
